led_shift_driver: RTL and testbench
===================================

Name: led_shift_driver

Overview:
- Downstream consumer of the 16-bit `leds` vector produced by the bound flasher.
- Serialises the vector onto an external daisy-chained shift-register LED driver (74HC595-style), MSB first, with a storage latch pulse.
- Transmits a frame only when the vector differs from the last transmitted value, plus one unconditional frame after reset.
- Changes that arrive mid-frame are coalesced into a single later frame.

Parameters:
- WIDTH, 16, number of LED bits per frame.
- DIV, 2, clk cycles per half-period of ser_clk and length of the latch pulse (legal range 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- leds  input  WIDTH  LED pattern from the flasher; sampled only in IDLE.
- ser_data  output  1  serial data to the external chain, MSB first.
- ser_clk  output  1  external shift clock; the external device samples on its rising edge.
- ser_latch  output  1  external storage-register latch pulse, active high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- One clock, asynchronous active-low reset (rst_n).
- All outputs come straight from flops; no combinational paths from input to output.

Reset (asynchronous, immediate, including mid-frame):
- ser_data=0, ser_clk=0, ser_latch=0, busy=0.
- state=IDLE, last_sent=0, init_pending=1.
- A frame in flight is aborted. After release, the initial frame is resent.

States: IDLE, SHIFT, LATCH.

IDLE:
- Each cycle, evaluate `init_pending || (leds != last_sent)`.
- If true: shadow <= leds, bit_cnt <= WIDTH-1, div_cnt <= 0, state <= SHIFT, busy <= 1, init_pending <= 0.
- ser_data for the first bit is driven from that same edge.

SHIFT:
- Each bit occupies 2*DIV cycles: ser_clk low for DIV cycles, then high for DIV cycles.
- ser_data = shadow[bit_cnt], stable for the whole 2*DIV window.
- It changes only on the edge where ser_clk returns low. Setup and hold to the ser_clk rising edge are therefore DIV cycles each.
- After the high phase of bit 0: ser_clk <= 0, ser_data <= 0, state <= LATCH.

LATCH:
- ser_latch high for exactly DIV cycles.
- Then ser_latch <= 0, busy <= 0, last_sent <= shadow, state <= IDLE.

Timing:
- Busy duration per frame = WIDTH*2*DIV + DIV cycles (66 at the defaults).
- Latency from a leds change (while idle) to busy rising = 1 cycle.

leds changes during SHIFT/LATCH:
- Ignored; shadow is frozen.
- On return to IDLE the comparison is repeated, so only the latest value is sent.
- Back-to-back frames have exactly one IDLE cycle between them.
- Intermediate values are deliberately dropped.

Other rules:
- Identical value: if leds equals last_sent, no frame is sent and busy stays 0 indefinitely.
- Counters: bit_cnt is clog2(WIDTH) bits, div_cnt is 4 bits. No wrap occurs within legal DIV.

Decomposition:
- Shared package led_drv_pkg:
  - State enum {IDLE, SHIFT, LATCH}, encoded in 2 bits.
  - Default WIDTH/DIV constants.
  - FRAME_CYCLES = WIDTH*2*DIV + DIV, for bench use.
- Sub-module led_shift_tick: div_cnt with a phase-end strobe (`tick` when div_cnt==DIV-1, then clear). The FSM uses it to advance phases.
- Shift/compare logic stays in the top module.

Test Plan:
- Reset release, leds=16'h0000 -> one initial frame. ser_data=0 for all 16 bits, 16 ser_clk rising edges, one ser_latch pulse of 2 cycles, busy high for 66 cycles, then idle with no further frames.
- leds set to 16'hA5C3 after the initial frame -> busy rises 1 cycle later. The chain model captures 16'hA5C3 (MSB first) at the ser_latch pulse, and ser_data is stable for 2 cycles on each side of every ser_clk rise.
- leds changed to 16'h0001, then 16'h8000, then 16'hFFFF during one frame -> exactly one further frame, carrying 16'hFFFF, starting 1 idle cycle after busy falls.
- leds held at the last sent value for 500 cycles -> no ser_clk, ser_latch or busy activity.
- rst_n pulsed low during bit 7 of a 16'h1234 frame -> all outputs drop to 0 asynchronously with no ser_latch. After release, an initial frame carrying the current leds value is sent.
- DIV=1, WIDTH=16, leds=16'h8001 -> busy for 33 cycles, 1-cycle ser_latch pulse, chain model captures 16'h8001.

Source files
------------

// File: rtl/led_drv_pkg.sv
// Shared types and constants for the LED shift-register driver.
package led_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_DIV      = 2;
  localparam int unsigned FRAME_CYCLES = DEF_WIDTH * 2 * DEF_DIV + DEF_DIV;

  function automatic int unsigned frame_cycles(input int unsigned width, input int unsigned div);
    return width * 2 * div + div;
  endfunction

endpackage

// File: rtl/led_shift_tick.sv
// Phase timer: strobes tick on the last cycle of each DIV-cycle phase, held cleared while not running.
module led_shift_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  logic [3:0] div_cnt;

  assign tick = run && (div_cnt == 4'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/led_shift_driver.sv
// Serialises the LED vector MSB first onto a 74HC595-style chain, sending only on change
// (plus once after reset); changes arriving mid-frame coalesce into one later frame.
module led_shift_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] leds,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] last_sent;
  logic [CW-1:0]    bit_cnt;
  logic             init_pending;
  logic             tick;

  led_shift_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state != IDLE),
    .tick  (tick)
  );

  // ser_clk doubles as the low/high phase flag within each bit window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      last_sent    <= '0;
      bit_cnt      <= '0;
      init_pending <= 1'b1;
      ser_data     <= 1'b0;
      ser_clk      <= 1'b0;
      ser_latch    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init_pending || (leds != last_sent)) begin
            shadow       <= leds;
            bit_cnt      <= CW'(WIDTH - 1);
            ser_data     <= leds[WIDTH-1];
            busy         <= 1'b1;
            init_pending <= 1'b0;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!ser_clk) begin
              ser_clk <= 1'b1;
            end else if (bit_cnt == '0) begin
              ser_clk   <= 1'b0;
              ser_data  <= 1'b0;
              ser_latch <= 1'b1;
              state     <= LATCH;
            end else begin
              ser_clk  <= 1'b0;
              bit_cnt  <= bit_cnt - 1'b1;
              ser_data <= shadow[bit_cnt - 1'b1];
            end
          end
        end
        LATCH: begin
          if (tick) begin
            ser_latch <= 1'b0;
            busy      <= 1'b0;
            last_sent <= shadow;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: frame-timer reference model checked every cycle, plus
// directed scenarios, a DIV=1 instance and randomized leds traffic.
module tb_led_shift_driver;
  import led_drv_pkg::*;

  localparam int unsigned W     = DEF_WIDTH;
  localparam int unsigned D     = DEF_DIV;
  localparam int unsigned FRAME = frame_cycles(W, D);

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] leds  = '0;
  logic [W-1:0] leds1 = 16'h8001;
  logic ser_data, ser_clk, ser_latch, busy;
  logic ser_data1, ser_clk1, ser_latch1, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_shift_driver #(.WIDTH(W), .DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .leds(leds),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch), .busy(busy)
  );

  led_shift_driver #(.WIDTH(16), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .leds(leds1),
    .ser_data(ser_data1), .ser_clk(ser_clk1), .ser_latch(ser_latch1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input logic lvl, input int max, input string name);
    int n = 0;
    while (busy !== lvl && n < max) begin
      step(1);
      n++;
    end
    if (busy !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: busy=%0b after %0d cycles, expected %0b", name, busy, max, lvl);
    end
  endtask

  // Reference model: a frame is a timer t counting cycles since its start.
  logic         m_active = 1'b0;
  logic         m_init   = 1'b1;
  int unsigned  m_t      = 0;
  logic [W-1:0] m_shadow = '0;
  logic [W-1:0] m_last   = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0;
      m_init   = 1'b1;
      m_last   = '0;
      m_t      = 0;
    end else if (m_active) begin
      if (m_t == FRAME - 1) begin
        m_active = 1'b0;
        m_last   = m_shadow;
      end else begin
        m_t++;
      end
    end else if (m_init || leds != m_last) begin
      m_active = 1'b1;
      m_t      = 0;
      m_shadow = leds;
      m_init   = 1'b0;
    end
  end

  // Expected {ser_data, ser_clk, ser_latch, busy}.
  function automatic logic [3:0] model_outs();
    int unsigned b;
    if (!m_active) return 4'b0000;
    if (m_t < W * 2 * D) begin
      b = W - 1 - m_t / (2 * D);
      return {m_shadow[b], logic'((m_t % (2 * D)) >= D), 1'b0, 1'b1};
    end
    return 4'b0011;
  endfunction

  initial forever begin
    @(negedge clk);
    check("outs", {28'd0, ser_data, ser_clk, ser_latch, busy}, {28'd0, model_outs()});
  end

  // Frame statistics from the default instance.
  int frames = 0, latches = 0, total_rises = 0;
  int cur_len = 0, busy_len = 0, cur_rises = 0, rises_len = 0;
  int cur_gap = 0, gap_len = 0, cur_latch = 0, latch_len = 0;
  logic prev_busy = 1'b0, prev_latch = 1'b0, prev_sclk = 1'b0;
  int busy1_cyc = 0, latch1_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (busy && !prev_busy) begin
      frames++;
      gap_len   = cur_gap;
      cur_len   = 0;
      cur_rises = 0;
    end
    if (busy) begin
      cur_len++;
      cur_gap = 0;
    end else begin
      if (prev_busy) begin
        busy_len  = cur_len;
        rises_len = cur_rises;
      end
      cur_gap++;
    end
    if (ser_clk && !prev_sclk) begin
      cur_rises++;
      total_rises++;
    end
    if (ser_latch) begin
      cur_latch++;
    end else if (prev_latch) begin
      latch_len = cur_latch;
      latches++;
      cur_latch = 0;
    end
    prev_busy  = busy;
    prev_latch = ser_latch;
    prev_sclk  = ser_clk;
    if (busy1) busy1_cyc++;
    if (ser_latch1) latch1_cyc++;
  end

  // External chain: shift on ser_clk rise, copy to outputs on latch rise.
  logic [W-1:0] chain = '0, latched = '0;
  logic [15:0]  chain1 = '0, latched1 = '0;

  initial forever begin @(posedge ser_clk);    chain    = {chain[W-2:0], ser_data};   end
  initial forever begin @(posedge ser_latch);  latched  = chain;                      end
  initial forever begin @(posedge ser_clk1);   chain1   = {chain1[14:0], ser_data1};  end
  initial forever begin @(posedge ser_latch1); latched1 = chain1;                     end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int f0, l0, r0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_data",  ser_data,  1'b0);
    check("rst_sclk",  ser_clk,   1'b0);
    check("rst_latch", ser_latch, 1'b0);
    check("rst_busy",  busy,      1'b0);
    step(2);
    rst_n = 1'b1;

    // Initial frame with leds=0, and the DIV=1 instance's initial frame of 8001.
    step(1);
    check("init_latency", busy, 1'b1);
    wait_for(1'b0, FRAME + 5, "init_end");
    check("init_busy_len", busy_len, 66);
    check("init_rises", rises_len, 16);
    check("init_latch_len", latch_len, 2);
    check("init_latches", latches, 1);
    check("init_data", latched, 16'h0000);
    check("div1_busy_len", busy1_cyc, 33);
    check("div1_latch_len", latch1_cyc, 1);
    check("div1_data", latched1, 16'h8001);
    step(20);
    check("init_single", frames, 1);

    leds = 16'hA5C3;
    step(1);
    check("a5c3_latency", busy, 1'b1);
    check("a5c3_model_shadow", m_shadow, 16'hA5C3);
    wait_for(1'b0, FRAME + 5, "a5c3_end");
    check("a5c3_data", latched, 16'hA5C3);
    check("a5c3_rises", rises_len, 16);
    check("a5c3_latch_len", latch_len, 2);

    // Several changes while busy coalesce into one frame with the latest value.
    step(3);
    leds = 16'h0001;
    step(1);
    check("c_latency", busy, 1'b1);
    f0 = frames;
    step(10);
    leds = 16'h8000;
    step(20);
    leds = 16'hFFFF;
    wait_for(1'b0, FRAME + 5, "c_first_end");
    check("c_first_data", latched, 16'h0001);
    wait_for(1'b1, 5, "c_restart");
    check("c_gap", gap_len, 1);
    wait_for(1'b0, FRAME + 5, "c_second_end");
    check("c_data", latched, 16'hFFFF);
    step(30);
    check("c_frames", frames, f0 + 1);

    f0 = frames;
    l0 = latches;
    r0 = total_rises;
    step(500);
    check("hold_frames", frames, f0);
    check("hold_latches", latches, l0);
    check("hold_rises", total_rises, r0);

    // Asynchronous reset during bit 7 (ser_clk high phase) of a 1234 frame.
    leds = 16'h1234;
    wait_for(1'b1, 5, "r_start");
    step(34);
    check("r_pre_sclk", ser_clk, 1'b1);
    l0 = latches;
    #2 rst_n = 1'b0;
    #1;
    check("r_data",  ser_data,  1'b0);
    check("r_sclk",  ser_clk,   1'b0);
    check("r_latch", ser_latch, 1'b0);
    check("r_busy",  busy,      1'b0);
    step(2);
    check("r_no_latch", latches, l0);
    rst_n = 1'b1;
    wait_for(1'b1, 5, "r_resend_start");
    wait_for(1'b0, FRAME + 5, "r_resend_end");
    check("r_resend_data", latched, 16'h1234);
    check("r_one_latch", latches, l0 + 1);

    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 150));
      case ($urandom_range(0, 3))
        0:       ;
        1:       leds = leds ^ (16'h1 << $urandom_range(0, 15));
        default: leds = 16'($urandom);
      endcase
    end
    step(2 * FRAME + 10);
    check("rand_idle", busy, 1'b0);
    check("rand_final", latched, leds);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
